ov7725_config_sequencer: RTL and testbench

Sequences the OV7725 register-configuration table onto the SCCB/I2C write master. After reset it waits a power-up delay, then steps the table index, reads each 16-bit entry ({reg_addr, value}) and issues one write per entry. NACKs are retried up to a bounded count, and a settle gap is inserted between writes. It sits between the combinational config LUT and the I2C byte-write engine, and reports done or error to the camera/VGA top level.

---
 rtl/ov7725_config_sequencer.sv | 133 +++++++++++++
 tb/tb_ov7725_config_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov7725_config_sequencer.sv
// Walks the OV7725 register table and issues one SCCB write per entry,
// with a power-up wait, bounded NACK retries and an idle gap between writes.
module ov7725_config_sequencer #(
  parameter int          LUT_FIRST = 3,
  parameter int          LUT_LAST  = 5,
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter logic [19:0] PWR_DLY   = 20'd1000000,
  parameter logic [19:0] GAP_DLY   = 20'd2000,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_cfg,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wr_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  cfg_count
);

  localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    IDX_FIRST = 8'(LUT_FIRST);
  localparam logic [7:0]    IDX_LAST  = 8'(LUT_LAST);
  // Terminal counts for the shared delay counter; a zero delay still takes one cycle.
  localparam logic [19:0]   PWR_END   = (PWR_DLY == 20'd0) ? 20'd0 : PWR_DLY - 20'd1;
  localparam logic [19:0]   GAP_END   = (GAP_DLY == 20'd0) ? 20'd0 : GAP_DLY - 20'd1;

  typedef enum logic [2:0] {PWR_WAIT, LOAD, WRITE, GAP, DONE, ERROR} state_t;

  state_t        state;
  logic [19:0]   dly_cnt;
  logic [RW-1:0] retry;
  logic          nacked;

  assign i2c_dev_addr = DEV_ADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PWR_WAIT;
      dly_cnt      <= '0;
      retry        <= '0;
      nacked       <= 1'b0;
      lut_index    <= IDX_FIRST;
      i2c_req      <= 1'b0;
      i2c_reg_addr <= '0;
      i2c_wr_data  <= '0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_count    <= '0;
    end else begin
      case (state)
        PWR_WAIT: begin
          cfg_busy <= 1'b1;
          if (dly_cnt >= PWR_END) begin
            dly_cnt   <= '0;
            lut_index <= IDX_FIRST;
            state     <= LOAD;
          end else begin
            dly_cnt <= dly_cnt + 20'd1;
          end
        end
        LOAD: begin
          i2c_reg_addr <= lut_data[15:8];
          i2c_wr_data  <= lut_data[7:0];
          i2c_req      <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          if (i2c_done) begin
            i2c_req <= 1'b0;
            if (!i2c_nack) begin
              if (cfg_count != 8'hff) cfg_count <= cfg_count + 8'd1;
              retry  <= '0;
              nacked <= 1'b0;
              state  <= GAP;
            end else if (retry < RETRY_MAX) begin
              retry  <= retry + 1'b1;
              nacked <= 1'b1;
              state  <= GAP;
            end else begin
              cfg_busy <= 1'b0;
              cfg_err  <= 1'b1;
              state    <= ERROR;
            end
          end
        end
        GAP: begin
          if (dly_cnt >= GAP_END) begin
            dly_cnt <= '0;
            // A retry skips LOAD: address and data are still held from the first attempt.
            if (nacked) begin
              i2c_req <= 1'b1;
              state   <= WRITE;
            end else if (lut_index == IDX_LAST) begin
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
              state    <= DONE;
            end else begin
              if (lut_index != 8'hff) lut_index <= lut_index + 8'd1;
              state <= LOAD;
            end
          end else begin
            dly_cnt <= dly_cnt + 20'd1;
          end
        end
        DONE, ERROR: begin
          if (start_cfg) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_count <= '0;
            retry     <= '0;
            nacked    <= 1'b0;
            dly_cnt   <= '0;
            lut_index <= IDX_FIRST;
            cfg_busy  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7725_config_sequencer.sv
// Bench for ov7725_config_sequencer: event-level timing model, directed
// scenarios with literal expectations, then randomized master behaviour.
module tb_ov7725_config_sequencer;

  localparam int PWR = 10, GAP = 4, FIRST = 3, LAST = 5, MAXR = 3;

  logic        clk = 1'b0, rst = 1'b1, start_cfg = 1'b0, i2c_done = 1'b0, i2c_nack = 1'b0;
  logic [7:0]  lut_index, i2c_dev_addr, i2c_reg_addr, i2c_wr_data, cfg_count;
  logic [15:0] lut_data;
  logic        i2c_req, cfg_busy, cfg_done, cfg_err;

  always #5 clk = ~clk;

  function automatic logic [15:0] lut(input logic [7:0] i);
    case (i)
      8'd3:    return 16'h1100;
      8'd4:    return 16'h1246;
      8'd5:    return 16'h0cd0;
      default: return {i ^ 8'h5a, i};
    endcase
  endfunction

  assign lut_data = lut(lut_index);

  ov7725_config_sequencer #(
    .LUT_FIRST(FIRST), .LUT_LAST(LAST), .DEV_ADDR(8'h42),
    .PWR_DLY(20'(PWR)), .GAP_DLY(20'(GAP)), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start_cfg(start_cfg), .lut_index(lut_index), .lut_data(lut_data),
    .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_wr_data(i2c_wr_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_count(cfg_count)
  );

  int checks = 0, failures = 0;

  // Model: m_wait counts edges until the next scheduled event (req rise, or done when m_fin).
  bit m_valid = 0, m_req, m_busy, m_done, m_err, m_fin;
  int m_idx, m_cnt, m_retry, m_wait;

  // Simulated master / stimulus knobs.
  int lat = -1, idle = 0, fixed_lat = 20, nack_mode = 0, nack_pct = 0, nack_left = 0;
  logic [7:0] nack_addr = 8'h00;
  bit spur = 0, start_in_write = 0;
  logic [15:0] wlog[$];
  int idleq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_valid = 1; m_req = 0; m_busy = 0; m_done = 0; m_err = 0; m_fin = 0;
      m_idx = FIRST; m_cnt = 0; m_retry = 0; m_wait = PWR + 1;
      return;
    end
    if (m_req && i2c_done) begin
      m_req = 0;
      if (!i2c_nack) begin
        m_cnt++; m_retry = 0;
        if (m_idx == LAST) begin m_fin = 1; m_wait = GAP; end
        else begin m_idx++; m_fin = 0; m_wait = GAP + 1; end
      end else if (m_retry < MAXR) begin
        m_retry++; m_fin = 0; m_wait = GAP;
      end else begin
        m_err = 1; m_wait = 0;
      end
    end else if ((m_done || m_err) && start_cfg) begin
      m_done = 0; m_err = 0; m_cnt = 0; m_retry = 0; m_idx = FIRST; m_fin = 0; m_wait = 1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_fin) m_done = 1; else m_req = 1;
      end
    end
    m_busy = !(m_done || m_err);
  endtask

  task automatic compare();
    logic [15:0] e;
    if (!m_valid) return;
    e = lut(8'(m_idx));
    chk("i2c_req", i2c_req, m_req);
    chk("cfg_busy", cfg_busy, m_busy);
    chk("cfg_done", cfg_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("cfg_count", cfg_count, m_cnt);
    chk("i2c_dev_addr", i2c_dev_addr, 8'h42);
    if (m_req) begin
      chk("i2c_reg_addr", i2c_reg_addr, e[15:8]);
      chk("i2c_wr_data", i2c_wr_data, e[7:0]);
    end
    if (m_req || m_done || m_err) chk("lut_index", lut_index, m_idx);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    i2c_done = 0; i2c_nack = 0; start_cfg = 0;
    if (rst) begin
      lat = -1; idle = 0;
    end else if (i2c_req) begin
      if (lat < 0) begin
        wlog.push_back({i2c_reg_addr, i2c_wr_data});
        idleq.push_back(idle);
        idle = 0;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
        if (start_in_write) start_cfg = 1;
      end
      if (lat == 0) begin
        i2c_done = 1;
        if (nack_mode == 1) i2c_nack = ($urandom_range(0, 99) < nack_pct);
        else if (nack_mode == 2 && i2c_reg_addr == nack_addr && nack_left > 0) begin
          i2c_nack = 1; nack_left--;
        end
        lat = -1;
      end else lat--;
    end else begin
      idle++; lat = -1;
      if (spur && $urandom_range(0, 15) == 0) begin
        i2c_done = 1; i2c_nack = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run_until(input int which, input int maxc, input string nm);
    for (int n = 0; n < maxc; n++) begin
      step();
      if ((which == 0 && cfg_done) || (which == 1 && cfg_err) || (which == 2 && i2c_req)) return;
    end
    checks++; failures++;
    $display("FAIL timeout %s after %0d cycles", nm, maxc);
  endtask

  task automatic restart();
    wlog.delete(); idleq.delete();
    start_cfg = 1;
    step();
  endtask

  initial begin
    int n, att;
    // Reset state
    repeat (3) step();
    chk("rst lut_index", lut_index, 8'd3);
    chk("rst i2c_req", i2c_req, 1'b0);
    chk("rst reg_addr", i2c_reg_addr, 8'h00);
    chk("rst busy", cfg_busy, 1'b0);

    // Nominal run: power-up wait then three writes
    rst = 0; n = 0;
    do begin step(); n++; end while (!i2c_req && n < 100);
    chk("first req cycle", n, 11);
    run_until(0, 300, "nominal done");
    chk("nominal writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("nominal w0", wlog[0], 16'h1100);
      chk("nominal w1", wlog[1], 16'h1246);
      chk("nominal w2", wlog[2], 16'h0cd0);
    end
    chk("nominal count", cfg_count, 8'd3);
    chk("nominal busy", cfg_busy, 1'b0);

    // Single NACK on entry 4; restart from DONE; start during WRITE ignored
    fixed_lat = 2; nack_mode = 2; nack_addr = 8'h12; nack_left = 1; start_in_write = 1;
    restart();
    chk("restart count cleared", cfg_count, 8'd0);
    chk("restart load no req", i2c_req, 1'b0);
    step();
    chk("restart req", i2c_req, 1'b1);
    chk("restart addr/data", {i2c_reg_addr, i2c_wr_data}, 16'h1100);
    run_until(0, 300, "nack done");
    start_in_write = 0;
    chk("nack writes", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("nack resend", wlog[2], 16'h1246);
      chk("gap after ack", idleq[1], 5);
      chk("gap after nack", idleq[2], 4);
      chk("nack last", wlog[3], 16'h0cd0);
    end
    chk("nack count", cfg_count, 8'd3);

    // Entry 5 always NACKed -> error after four attempts
    nack_addr = 8'h0c; nack_left = 100;
    restart();
    run_until(1, 400, "error");
    att = 0;
    foreach (wlog[i]) if (wlog[i] == 16'h0cd0) att++;
    chk("error attempts", att, 4);
    chk("error lut_index", lut_index, 8'd5);
    chk("error count", cfg_count, 8'd2);
    repeat (30) step();
    chk("no req after error", wlog.size(), 6);

    // Reset during a transaction, spurious done pulses in power wait
    nack_mode = 0;
    restart();
    run_until(2, 20, "req before reset");
    rst = 1;
    step();
    chk("mid rst req", i2c_req, 1'b0);
    chk("mid rst index", lut_index, 8'd3);
    rst = 0; spur = 1; n = 0;
    do begin step(); n++; end while (!i2c_req && n < 100);
    chk("req after mid rst", n, 11);

    // Randomized traffic
    fixed_lat = -1; nack_mode = 1;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) nack_pct = int'($urandom_range(0, 80));
      step();
      rst = ($urandom_range(0, 599) == 0);
      if (!rst && $urandom_range(0, 29) == 0) start_cfg = 1;
    end
    rst = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
